// File: rtl/runner_pos_gen.sv
// Ping-pong one-hot runner with stop/score game logic, feeding the 7-segment runner decoder.
// All outputs registered; a stop press acts at the next clk edge; enable low freezes all state.
module runner_pos_gen #(
   parameter int unsigned TICK_DIV   = 25000000,
   parameter int unsigned TARGET_IDX = 3,
   parameter int unsigned HOLD_STEPS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       btn_stop,
   input  logic [1:0] speed_sel,
   output logic [7:0] pos_onehot,
   output logic       running,
   output logic       hit,
   output logic       miss,
   output logic [3:0] score
);

   localparam int unsigned STEP_W   = $clog2(TICK_DIV);
   localparam int unsigned HOLD_CYC = HOLD_STEPS * TICK_DIV;
   localparam int unsigned HOLD_W   = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
   localparam logic [2:0]        TGT       = 3'(TARGET_IDX);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [7:0]          pos_q, pos_d;
   logic                dir_q, dir_d;          // 1 = moving toward MSB
   logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic                btn_prev_q, btn_prev_d;
   logic [3:0]          score_q, score_d;
   logic                hit_q, hit_d;
   logic                miss_q, miss_d;
   logic                running_q, running_d;

   logic                stop_evt;
   logic [STEP_W-1:0]   step_last;

   assign stop_evt  = btn_stop & ~btn_prev_q;
   // Live speed compare: a counter left above a shorter period wraps and steps at once.
   assign step_last = STEP_W'((TICK_DIV >> speed_sel) - 1);

   always_comb begin
      state_d    = state_q;
      pos_d      = pos_q;
      dir_d      = dir_q;
      step_cnt_d = step_cnt_q;
      hold_cnt_d = hold_cnt_q;
      btn_prev_d = btn_prev_q;
      score_d    = score_q;
      hit_d      = 1'b0;
      miss_d     = 1'b0;

      if (enable) begin
         btn_prev_d = btn_stop;
         case (state_q)
            S_IDLE: begin
               if (stop_evt) begin
                  state_d    = S_RUN;
                  step_cnt_d = '0;
               end
            end
            S_RUN: begin
               if (stop_evt) begin
                  state_d    = S_HOLD;
                  hold_cnt_d = '0;
                  step_cnt_d = '0;
                  if (pos_q[TGT]) begin
                     hit_d = 1'b1;
                     if (score_q != 4'hf) begin
                        score_d = score_q + 4'd1;
                     end
                  end else begin
                     miss_d = 1'b1;
                  end
               end else if (step_cnt_q >= step_last) begin
                  step_cnt_d = '0;
                  if (dir_q) begin
                     if (pos_q[7]) begin
                        pos_d = 8'h40;
                        dir_d = 1'b0;
                     end else begin
                        pos_d = pos_q << 1;
                     end
                  end else begin
                     if (pos_q[0]) begin
                        pos_d = 8'h02;
                        dir_d = 1'b1;
                     end else begin
                        pos_d = pos_q >> 1;
                     end
                  end
               end else begin
                  step_cnt_d = step_cnt_q + STEP_W'(1);
               end
            end
            S_HOLD: begin
               if (hold_cnt_q == HOLD_LAST) begin
                  state_d    = S_RUN;
                  hold_cnt_d = '0;
                  step_cnt_d = '0;
               end else begin
                  hold_cnt_d = hold_cnt_q + HOLD_W'(1);
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      running_d = (state_d == S_RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pos_q      <= 8'h80;
         dir_q      <= 1'b0;
         step_cnt_q <= '0;
         hold_cnt_q <= '0;
         btn_prev_q <= 1'b0;
         score_q    <= 4'd0;
         hit_q      <= 1'b0;
         miss_q     <= 1'b0;
         running_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pos_q      <= pos_d;
         dir_q      <= dir_d;
         step_cnt_q <= step_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         btn_prev_q <= btn_prev_d;
         score_q    <= score_d;
         hit_q      <= hit_d;
         miss_q     <= miss_d;
         running_q  <= running_d;
      end
   end

   assign pos_onehot = pos_q;
   assign running    = running_q;
   assign hit        = hit_q;
   assign miss       = miss_q;
   assign score      = score_q;

endmodule

// File: tb/tb_runner_pos_gen.sv
// Bench for runner_pos_gen: cycle model of the game rules plus directed literal checks.
module tb_runner_pos_gen;

   localparam int TICK_DIV   = 8;
   localparam int HOLD_STEPS = 4;
   localparam int TARGET_IDX = 3;

   logic       clk;
   logic       rst;
   logic       enable;
   logic       btn_stop;
   logic [1:0] speed_sel;
   logic [7:0] pos_onehot;
   logic       running;
   logic       hit;
   logic       miss;
   logic [3:0] score;

   int checks = 0;
   int errors = 0;
   bit cmp_on = 0;

   runner_pos_gen #(
      .TICK_DIV  (TICK_DIV),
      .TARGET_IDX(TARGET_IDX),
      .HOLD_STEPS(HOLD_STEPS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .btn_stop  (btn_stop),
      .speed_sel (speed_sel),
      .pos_onehot(pos_onehot),
      .running   (running),
      .hit       (hit),
      .miss      (miss),
      .score     (score)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Game model: k is the position along the 14-entry ping-pong cycle starting at 8'h80.
   typedef struct {
      int   mode;   // 0 idle, 1 run, 2 hold
      int   k;
      int   cnt;
      int   hold;
      int   score;
      logic prev;
      logic hit;
      logic miss;
   } mst_t;

   mst_t m;

   function automatic logic [7:0] pos_of(input int k);
      int idx;
      logic [7:0] one;
      idx = (k < 7) ? (7 - k) : (k - 7);
      one = 8'd1;
      return one << idx;
   endfunction

   function automatic mst_t model_next(input mst_t s, input logic r, input logic en,
                                       input logic b, input logic [1:0] spd);
      mst_t n;
      logic [7:0] p;
      n = s;
      n.hit  = 1'b0;
      n.miss = 1'b0;
      if (r) begin
         n.mode = 0; n.k = 0; n.cnt = 0; n.hold = 0; n.score = 0; n.prev = 1'b0;
      end else if (en) begin
         n.prev = b;
         if (s.mode == 0) begin
            if (b && !s.prev) begin
               n.mode = 1;
               n.cnt  = 0;
            end
         end else if (s.mode == 1) begin
            if (b && !s.prev) begin
               n.mode = 2;
               n.hold = 0;
               p = pos_of(s.k);
               if (p[TARGET_IDX]) begin
                  n.hit   = 1'b1;
                  n.score = (s.score < 15) ? s.score + 1 : 15;
               end else begin
                  n.miss = 1'b1;
               end
            end else begin
               n.cnt = s.cnt + 1;
               if (n.cnt >= (TICK_DIV >> spd)) begin
                  n.cnt = 0;
                  n.k   = (s.k + 1) % 14;
               end
            end
         end else begin
            n.hold = s.hold + 1;
            if (n.hold >= HOLD_STEPS * TICK_DIV) begin
               n.mode = 1;
               n.cnt  = 0;
               n.hold = 0;
            end
         end
      end
      return n;
   endfunction

   always @(posedge clk) m <= model_next(m, rst, enable, btn_stop, speed_sel);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_on) begin
         chk("model_pos", pos_onehot, pos_of(m.k));
         chk("model_running", running, m.mode == 1);
         chk("model_hit", hit, m.hit);
         chk("model_miss", miss, m.miss);
         chk("model_score", score, m.score);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_run_pos(input logic [7:0] p, input string nm);
      int n;
      n = 0;
      while (!(pos_onehot == p && running) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk(nm, n < 400, 1);
   endtask

   task automatic wait_step(input string nm);
      int n;
      logic [7:0] rec;
      n = 0;
      rec = pos_onehot;
      while (!(pos_onehot != rec && running) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk(nm, n < 400, 1);
   endtask

   logic [7:0] seq [16];
   logic [7:0] rec;

   initial begin
      seq = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
              8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40};
      rst = 1'b1; enable = 1'b1; btn_stop = 1'b0; speed_sel = 2'd0;
      tick(3);
      rst = 1'b0;
      cmp_on = 1'b1;

      // Idle after reset
      tick(50);
      chk("idle_pos", pos_onehot, 8'h80);
      chk("idle_running", running, 0);
      chk("idle_score", score, 0);

      // Start and walk the full ping-pong sequence; button stays high (no retrigger)
      btn_stop = 1'b1;
      tick(1);
      chk("start_running", running, 1);
      for (int i = 0; i < 16; i++) begin
         chk("seq_pos", pos_onehot, seq[i]);
         tick(8);
      end
      btn_stop = 1'b0;

      // Hit on 8'h08, with a press inside HOLD that must be ignored
      wait_run_pos(8'h08, "wait_first_08");
      btn_stop = 1'b1;
      tick(1);
      chk("hit_pulse", hit, 1);
      chk("hit_no_miss", miss, 0);
      chk("hit_score", score, 1);
      btn_stop = 1'b0;
      tick(1);
      chk("hit_one_cycle", hit, 0);
      tick(4);
      btn_stop = 1'b1;
      tick(2);
      btn_stop = 1'b0;
      tick(32);
      chk("hold_frozen", pos_onehot, 8'h08);
      tick(1);
      chk("resume_pos", pos_onehot, 8'h04);

      // Speed changes
      speed_sel = 2'd3;
      for (int i = 0; i < 6; i++) begin
         rec = pos_onehot;
         tick(1);
         chk("fast_step", pos_onehot != rec, 1);
      end
      speed_sel = 2'd1;
      rec = pos_onehot;
      tick(3);
      chk("sp1_hold", pos_onehot, rec);
      tick(1);
      chk("sp1_step", pos_onehot != rec, 1);
      speed_sel = 2'd0;

      // Miss on 8'h20
      wait_run_pos(8'h20, "wait_20");
      btn_stop = 1'b1;
      tick(1);
      chk("miss_pulse", miss, 1);
      chk("miss_no_hit", hit, 0);
      chk("miss_score", score, 1);
      btn_stop = 1'b0;

      // Repeated hits saturate the score
      for (int i = 0; i < 17; i++) begin
         wait_run_pos(8'h08, "wait_08");
         btn_stop = 1'b1;
         tick(1);
         chk("rep_hit", hit, 1);
         chk("rep_score", score, (i + 2 < 15) ? i + 2 : 15);
         btn_stop = 1'b0;
      end

      // Stop edge coincident with a step tick
      wait_step("wait_step_coinc");
      tick(7);
      rec = pos_onehot;
      btn_stop = 1'b1;
      tick(1);
      chk("coinc_no_advance", pos_onehot, rec);
      chk("coinc_stopped", running, 0);
      btn_stop = 1'b0;

      // Enable low mid-RUN, with a button pulse that must be ignored
      wait_step("wait_step_en");
      tick(3);
      rec = pos_onehot;
      enable = 1'b0;
      tick(2);
      btn_stop = 1'b1;
      tick(3);
      btn_stop = 1'b0;
      tick(15);
      chk("en_frozen", pos_onehot, rec);
      chk("en_running", running, 1);
      enable = 1'b1;
      tick(4);
      chk("en_remaining", pos_onehot, rec);
      tick(1);
      chk("en_step", pos_onehot != rec, 1);

      // Reset during HOLD
      btn_stop = 1'b1;
      tick(1);
      btn_stop = 1'b0;
      tick(5);
      rst = 1'b1;
      tick(1);
      chk("rst_pos", pos_onehot, 8'h80);
      chk("rst_running", running, 0);
      chk("rst_score", score, 0);
      rst = 1'b0;
      tick(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
